// File: rtl/param_stream_flatten_if.sv
// Element stream into the parameter flattener: data/valid from the source, ready back from the sink.
interface param_stream_flatten_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/param_stream_flatten.sv
// Loads MLP weights/biases from an element stream into flattened layer buses.
// Optional trailing checksum check is compiled in with `define PARAM_CHECKSUM_EN.
module param_stream_flatten #(
   parameter int DATA_W = 8,
   parameter int N_IN   = 62,
   parameter int N_HID  = 20,
   parameter int N_OUT  = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   param_stream_flatten_if.slave          s,
   output logic [N_IN*N_HID*DATA_W-1:0]   weight_h,
   output logic [N_HID*DATA_W-1:0]        bias_h,
   output logic [N_HID*N_OUT*DATA_W-1:0]  weight_out,
   output logic [N_OUT*DATA_W-1:0]        bias_out,
   output logic                           busy,
   output logic                           params_valid,
   output logic                           cksum_err
);

   localparam int NWH   = N_IN * N_HID;
   localparam int NBH   = N_HID;
   localparam int NWO   = N_HID * N_OUT;
   localparam int NBO   = N_OUT;
   localparam int MAX_W = (NWH > NWO) ? NWH : NWO;
   localparam int MAX_B = (NBH > NBO) ? NBH : NBO;
   localparam int MAXL  = (MAX_W > MAX_B) ? MAX_W : MAX_B;
   localparam int CNT_W = (MAXL > 1) ? $clog2(MAXL) : 1;

   localparam logic [CNT_W-1:0] LAST_WH = CNT_W'(NWH - 1);
   localparam logic [CNT_W-1:0] LAST_BH = CNT_W'(NBH - 1);
   localparam logic [CNT_W-1:0] LAST_WO = CNT_W'(NWO - 1);
   localparam logic [CNT_W-1:0] LAST_BO = CNT_W'(NBO - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_WH, LOAD_BH, LOAD_WO, LOAD_BO, DONE
`ifdef PARAM_CHECKSUM_EN
      , CHECK
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             loading;
   logic             last;
   logic             xfer;
   logic             start_ok;

`ifdef PARAM_CHECKSUM_EN
   logic [15:0] sum;
   logic [7:0]  chk_lo;
   logic        err_q;

   function automatic logic [15:0] ext16(input logic [DATA_W-1:0] d);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < DATA_W && i < 16; i++) r[i] = d[i];
      return r;
   endfunction

   function automatic logic [7:0] low8(input logic [DATA_W-1:0] d);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < DATA_W && i < 8; i++) r[i] = d[i];
      return r;
   endfunction
`endif

   always_comb begin
      loading = (state == LOAD_WH) || (state == LOAD_BH) ||
                (state == LOAD_WO) || (state == LOAD_BO);
`ifdef PARAM_CHECKSUM_EN
      if (state == CHECK) loading = 1'b1;
`endif
   end

   always_comb begin
      last = 1'b0;
      case (state)
         LOAD_WH: last = (cnt == LAST_WH);
         LOAD_BH: last = (cnt == LAST_BH);
         LOAD_WO: last = (cnt == LAST_WO);
         LOAD_BO: last = (cnt == LAST_BO);
`ifdef PARAM_CHECKSUM_EN
         CHECK:   last = (cnt == CNT_W'(1));
`endif
         default: last = 1'b0;
      endcase
   end

   assign s.in_ready = loading;
   assign busy       = loading;
   assign xfer       = s.in_valid && loading;
   // A start is only honoured when no load is running, so it can never coincide with a transfer.
   assign start_ok   = start && ((state == IDLE) || (state == DONE));

`ifdef PARAM_CHECKSUM_EN
   assign cksum_err = err_q;
`else
   assign cksum_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         weight_h     <= '0;
         bias_h       <= '0;
         weight_out   <= '0;
         bias_out     <= '0;
         params_valid <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
         sum          <= '0;
         chk_lo       <= '0;
         err_q        <= 1'b0;
`endif
      end else if (start_ok) begin
         state        <= LOAD_WH;
         cnt          <= '0;
         params_valid <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
         sum          <= '0;
         err_q        <= 1'b0;
`endif
      end else if (xfer) begin
         // Element k of the active segment lands in slice k of its bus; all other bits hold.
         case (state)
            LOAD_WH: for (int k = 0; k < NWH; k++)
               if (cnt == CNT_W'(k)) weight_h[k*DATA_W +: DATA_W] <= s.in_data;
            LOAD_BH: for (int k = 0; k < NBH; k++)
               if (cnt == CNT_W'(k)) bias_h[k*DATA_W +: DATA_W] <= s.in_data;
            LOAD_WO: for (int k = 0; k < NWO; k++)
               if (cnt == CNT_W'(k)) weight_out[k*DATA_W +: DATA_W] <= s.in_data;
            LOAD_BO: for (int k = 0; k < NBO; k++)
               if (cnt == CNT_W'(k)) bias_out[k*DATA_W +: DATA_W] <= s.in_data;
`ifdef PARAM_CHECKSUM_EN
            CHECK: if (cnt == '0) chk_lo <= low8(s.in_data);
`endif
            default: ;
         endcase
`ifdef PARAM_CHECKSUM_EN
         if (state != CHECK) sum <= sum + ext16(s.in_data);
`endif
         if (last) begin
            cnt <= '0;
            case (state)
               LOAD_WH: state <= LOAD_BH;
               LOAD_BH: state <= LOAD_WO;
               LOAD_WO: state <= LOAD_BO;
`ifdef PARAM_CHECKSUM_EN
               LOAD_BO: state <= CHECK;
               CHECK: begin
                  if ({low8(s.in_data), chk_lo} == sum) begin
                     state        <= DONE;
                     params_valid <= 1'b1;
                  end else begin
                     state <= IDLE;
                     err_q <= 1'b1;
                  end
               end
`else
               LOAD_BO: begin
                  state        <= DONE;
                  params_valid <= 1'b1;
               end
`endif
               default: state <= IDLE;
            endcase
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/param_stream_flatten.md
Name: param_stream_flatten

Overview:
- Parametrised, sequential successor to the static weight/bias flattener for the MLP datapath.
- Loads network parameters at run time from a byte stream (DMA or host FIFO) instead of elaboration-time file reads, and packs them into flattened buses for the hidden and output layers.
- Asserts params_valid once every weight and bias has been loaded.
- Layer sizes and element width are generics, so one block serves every network configuration.

Parameters:
- DATA_W, 8, bits per weight/bias element.
- N_IN, 62, inputs per hidden neuron.
- N_HID, 20, hidden neurons.
- N_OUT, 10, output neurons.
- All parameters must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- in_data  input  DATA_W  stream element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts an element this cycle.
- weight_h  output  N_IN*N_HID*DATA_W  hidden weights, flattened.
- bias_h  output  N_HID*DATA_W  hidden biases.
- weight_out  output  N_HID*N_OUT*DATA_W  output weights.
- bias_out  output  N_OUT*DATA_W  output biases.
- busy  output  1  load in progress.
- params_valid  output  1  all buses hold a complete parameter set.
- cksum_err  output  1  checksum mismatch (see Optional Feature).

Behaviour:
- Reset (clk edge with rst=1):
  - State IDLE; all buses, counter, busy, params_valid and cksum_err are 0.
  - Reset mid-load aborts the load and zeroes everything.
- A transfer occurs on any clk edge with in_valid && in_ready.
- in_ready is combinational: 1 exactly in the LOAD_* and CHECK states.
- States and segment lengths, in stream order:
  - IDLE
  - LOAD_WH: NWH = N_IN*N_HID elements
  - LOAD_BH: NBH = N_HID elements
  - LOAD_WO: NWO = N_HID*N_OUT elements
  - LOAD_BO: NBO = N_OUT elements
  - DONE
- Transitions:
  - IDLE --start--> LOAD_WH.
  - Each LOAD_x moves to the next state on the transfer of its last element (counter == len-1).
  - The counter resets to 0 on each state change.
  - LOAD_BO advances to DONE, or to CHECK when the checksum feature is compiled in.
- Packing:
  - Element k of a segment is written to bits [DATA_W*k +: DATA_W] of its bus, in the same clk edge as the transfer.
  - No other bits change.
  - Element 0 of the hidden weights is neuron 0 / input 0; the index is neuron*N_IN + input.
  - Output weights use the index out_neuron*N_HID + hid.
- Counter width is clog2 of the largest segment length; it never wraps inside a segment.
- Stalls: in_valid low holds state and counter; there is no timeout.
- busy = 1 in LOAD_*/CHECK.
- params_valid is registered:
  - Set on the edge entering DONE.
  - Cleared on the edge a restart is accepted.
- start handling:
  - start in IDLE or DONE begins a new load.
  - start during LOAD_*/CHECK is ignored.
  - A start coinciding with a transfer is ignored.
- On restart the buses keep their old contents until each element is overwritten. Consumers must gate on params_valid.
- Latency: params_valid rises 1 cycle after the final element transfer. Minimum load time is NWH+NBH+NWO+NBO cycles after start.
- Without the optional feature, cksum_err is held 0.

Optional Feature:
- Macro: PARAM_CHECKSUM_EN.
- Defined:
  - A 16-bit running sum (mod 2^16) of all elements, zero-extended, is cleared on start.
  - After LOAD_BO, state CHECK accepts 2 elements carrying the expected sum (low DATA_W bits of each), LSB byte first.
  - On the second CHECK transfer:
    - Match: enter DONE, params_valid=1, cksum_err=0.
    - Mismatch: return to IDLE, params_valid=0, cksum_err=1.
  - cksum_err is sticky until the next start or rst.
- Undefined: there is no CHECK state, no sum register, and cksum_err is tied 0.

Test Plan:
- Reset/idle, params N_IN=2, N_HID=2, N_OUT=2, DATA_W=8:
  - Hold rst 2 cycles, then in_valid=1 with no start.
  - Required: in_ready=0, busy=0, params_valid=0, all buses 0.
- Full load, same params:
  - start, then 12 back-to-back bytes 0x01..0x0C.
  - Required: weight_h=0x04030201, bias_h=0x0605, weight_out=0x0A090807, bias_out=0x0C0B.
  - Required: params_valid=1 on the cycle after byte 0x0C; busy falls at the same edge.
- Stalls: same load with in_valid low for 3 cycles after bytes 2 and 9.
  - Required: identical bus values; params_valid is 6 cycles later than in the full-load case.
- Start during load and restart:
  - Pulse start at byte 5; required: ignored.
  - After DONE, pulse start; required: params_valid=0 next cycle and buses unchanged.
  - Stream 0xFF x12; required: all buses all-ones and params_valid=1.
- Reset mid-load: assert rst after byte 7.
  - Required: state IDLE, all buses 0, in_ready=0.
  - A fresh 12-byte load then completes normally.
- PARAM_CHECKSUM_EN: bytes 0x01..0x0C (sum 0x004E).
  - Trailer 0x4E,0x00: required params_valid=1, cksum_err=0.
  - Trailer 0x4F,0x00: required params_valid=0, cksum_err=1, state IDLE.
